alu_sched: RTL and testbench

- Two-requester scheduler that shares the single EX-stage ALU between the pipeline (req 0) and the auxiliary unit (req 1: address/debug calculations).
- Arbitrates with valid/ready handshakes and registers the issued operation into an ALU issue stage.
- Captures the ALU result into a response stage with back-pressure.
- Owns the architectural N/V/Z flag register and its per-opcode write-enable rules.

---
 rtl/alu_sched.sv | 163 ++++++++++++++++
 tb/tb_alu_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// alu_sched: two-requester scheduler for the shared EX-stage ALU.
// Requester 0 is the pipeline and requester 1 is the auxiliary unit.
// Pipeline: accept (N) -> issue register drives alu_* (N+1) -> response register (N+2).
// Also owns the {N,V,Z} flag register.
// Optional macro ALU_SCHED_PRIO_EN: when defined, requester 0 has fixed priority
// and the round-robin pointer is removed.
module alu_sched #(
  parameter int CNT_W  = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_n,
  input  logic              alu_v,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_data,
  output logic [2:0]        flag,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1
);

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_PADDSB = 4'b0111;

  logic              r_iss_vld;
  logic              r_iss_id;
  logic [3:0]        r_alu_op;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic              r_rsp_vld;
  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_fn, r_fv, r_fz;
  logic [CNT_W-1:0]  r_cnt0, r_cnt1;

  logic w_adv;    // issue stage may move into the response stage
  logic w_stall;  // issue stage full and stuck
  logic w_cap;    // issue op captured into response this cycle
  logic w_g0, w_g1;
  logic w_wr_z, w_wr_nv;

  assign w_adv   = !r_rsp_vld || resp_ready;
  assign w_stall = r_iss_vld && !w_adv;
  assign w_cap   = r_iss_vld && w_adv;

`ifdef ALU_SCHED_PRIO_EN
  assign w_g0 = !w_stall && req0_valid;
  assign w_g1 = !w_stall && req1_valid && !req0_valid;
`else
  // r_last_gnt names the previous winner; the other side wins a tie.
  logic r_last_gnt;
  assign w_g0 = !w_stall && req0_valid && (!req1_valid || r_last_gnt);
  assign w_g1 = !w_stall && req1_valid && (!req0_valid || !r_last_gnt);

  // Round-robin pointer moves only on a real grant; reset leaves requester 0 favoured
  always_ff @(posedge clk) begin
    if (rst)       r_last_gnt <= 1'b1;
    else if (w_g0) r_last_gnt <= 1'b0;
    else if (w_g1) r_last_gnt <= 1'b1;
  end
`endif

  assign req0_ready = w_g0;
  assign req1_ready = w_g1;

  // Issue stage: load the granted op; empties when it drains with nothing new
  always_ff @(posedge clk) begin
    if (rst) begin
      r_iss_vld <= 1'b0;
      r_iss_id  <= 1'b0;
      r_alu_op  <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
    end else if (!w_stall) begin
      r_iss_vld <= w_g0 || w_g1;
      if (w_g0) begin
        r_iss_id <= 1'b0;
        r_alu_op <= req0_op;
        r_alu_a  <= req0_a;
        r_alu_b  <= req0_b;
      end else if (w_g1) begin
        r_iss_id <= 1'b1;
        r_alu_op <= req1_op;
        r_alu_a  <= req1_a;
        r_alu_b  <= req1_b;
      end
    end
  end

  // Response stage: capture ALU result, hold id/data while back-pressured
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_vld  <= 1'b0;
      r_rsp_id   <= 1'b0;
      r_rsp_data <= '0;
    end else if (w_cap) begin
      r_rsp_vld  <= 1'b1;
      r_rsp_id   <= r_iss_id;
      r_rsp_data <= alu_out;
    end else if (resp_ready) begin
      r_rsp_vld  <= 1'b0;
    end
  end

  // Z for ADD/SUB/XOR/SLL/SRA/ROR; N,V only for ADD/SUB
  assign w_wr_z  = !r_alu_op[3] && (r_alu_op != OP_RED) && (r_alu_op != OP_PADDSB);
  assign w_wr_nv = (r_alu_op == OP_ADD) || (r_alu_op == OP_SUB);

  // Flags change only when the issued op lands in the response stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fn <= 1'b0;
      r_fv <= 1'b0;
      r_fz <= 1'b0;
    end else if (w_cap) begin
      if (w_wr_z)  r_fz <= (alu_out == '0);
      if (w_wr_nv) begin
        r_fn <= alu_n;
        r_fv <= alu_v;
      end
    end
  end

  // Saturating per-requester grant counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_g0 && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + 1'b1;
      if (w_g1 && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign alu_op     = r_alu_op;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign resp_valid = r_rsp_vld;
  assign resp_id    = r_rsp_id;
  assign resp_data  = r_rsp_data;
  assign flag       = {r_fn, r_fv, r_fz};
  assign gnt_cnt0   = r_cnt0;
  assign gnt_cnt1   = r_cnt1;

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: directed steps with a response scoreboard and an ALU model.
module tb_alu_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op, alu_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_out;
  logic        alu_n, alu_v;
  logic        resp_valid, resp_ready, resp_id;
  logic [15:0] resp_data;
  logic [2:0]  flag;
  logic [15:0] gnt_cnt0, gnt_cnt1;

  always #5 clk = ~clk;

  alu_sched #(.CNT_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_n(alu_n), .alu_v(alu_v),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .flag(flag),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  // ALU model: returns {n, v, out}. Non-ADD/SUB ops report n=v=1 so that
  // a flag written by the wrong opcode becomes visible.
  function automatic logic [17:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s;
    logic n, v;
    n = 1'b1; v = 1'b1;
    case (op)
      4'd0: begin s = a + b; n = s[15]; v = (a[15] == b[15]) && (s[15] != a[15]); end
      4'd1: begin s = a - b; n = s[15]; v = (a[15] != b[15]) && (s[15] != a[15]); end
      4'd2: s = a ^ b;
      4'd3: s = a & b;
      4'd4: s = a << b[3:0];
      4'd5: s = 16'($signed(a) >>> b[3:0]);
      4'd6: s = (a >> b[3:0]) | (a << (5'd16 - {1'b0, b[3:0]}));
      4'd7: s = a | b;
      default: s = a + b;
    endcase
    return {n, v, s};
  endfunction

  logic [17:0] w_alu;
  assign w_alu   = alu_f(alu_op, alu_a, alu_b);
  assign alu_n   = w_alu[17];
  assign alu_v   = w_alu[16];
  assign alu_out = w_alu[15:0];

  typedef struct {
    logic        id;
    logic [15:0] data;
    logic [2:0]  flag;
  } exp_t;
  exp_t sb[$];

  int          nvec = 0;
  int          nerr = 0;
  logic [2:0]  m_flag = 3'b000;
  logic        acc, acc_id, s_r0, s_r1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Record expected result and post-op flags in acceptance order
  task automatic push(input logic id, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [17:0] r;
    exp_t e;
    r = alu_f(op, a, b);
    if (!op[3] && op != 4'd3 && op != 4'd7) m_flag[0] = (r[15:0] == 16'h0);
    if (op == 4'd0 || op == 4'd1) m_flag[2:1] = r[17:16];
    e.id = id; e.data = r[15:0]; e.flag = m_flag;
    sb.push_back(e);
  endtask

  // One clock: observe handshakes at negedge, then return 1 time unit after posedge
  task automatic tick();
    exp_t e;
    @(negedge clk);
    s_r0 = req0_ready; s_r1 = req1_ready; acc = 1'b0;
    chk("one_ready", {31'b0, s_r0 & s_r1}, 32'd0);
    if (!rst) begin
      if (req0_valid && s_r0) begin
        push(1'b0, req0_op, req0_a, req0_b); acc = 1'b1; acc_id = 1'b0;
      end else if (req1_valid && s_r1) begin
        push(1'b1, req1_op, req1_a, req1_b); acc = 1'b1; acc_id = 1'b1;
      end
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) chk("spurious_resp", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("resp_id", {31'b0, resp_id}, {31'b0, e.id});
          chk("resp_data", {16'b0, resp_data}, {16'b0, e.data});
          chk("resp_flag", {29'b0, flag}, {29'b0, e.flag});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic id, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    if (!id) begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    else     begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    if (!id) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1; resp_ready = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_id", {31'b0, resp_id}, 32'd0);
    chk("rst_resp_data", {16'b0, resp_data}, 32'd0);
    chk("rst_flag", {29'b0, flag}, 32'd0);
    chk("rst_alu", {alu_op, alu_a, alu_b[11:0]}, 32'd0);
    chk("rst_cnt", {gnt_cnt0, gnt_cnt1}, 32'd0);

    // ADD latency: ready in N, alu_* in N+1, response in N+2
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 16'h0003; req0_b = 16'h0005;
    tick();
    chk("add_ready_N", {31'b0, s_r0}, 32'd1);
    req0_valid = 1'b0;
    chk("add_alu_op_N1", {28'b0, alu_op}, 32'd0);
    chk("add_alu_a_N1", {16'b0, alu_a}, 32'h3);
    tick();
    chk("add_resp_valid_N2", {31'b0, resp_valid}, 32'd1);
    chk("add_resp_data_N2", {16'b0, resp_data}, 32'h8);
    chk("add_flag_N2", {29'b0, flag}, 32'd0);
    drain();

    // SUB overflow -> 110, then XOR zero from requester 1 -> 111
    send(1'b0, 4'd1, 16'h7FFF, 16'hFFFF);
    drain();
    chk("sub_flag", {29'b0, flag}, 32'b110);
    send(1'b1, 4'd2, 16'h1234, 16'h1234);
    drain();
    chk("xor_flag", {29'b0, flag}, 32'b111);

    // Clear flags with ADD, then RED/PADDSB/LW yielding zero leave them alone
    send(1'b0, 4'd0, 16'h0001, 16'h0001);
    send(1'b0, 4'd3, 16'h0000, 16'h0000);
    send(1'b1, 4'd7, 16'h0000, 16'h0000);
    send(1'b0, 4'd8, 16'h0000, 16'h0000);
    drain();
    chk("noflag_ops", {29'b0, flag}, 32'b000);

    // Back-pressure: response holds op1, issue holds op2, op3 waits
    resp_ready = 1'b0;
    send(1'b0, 4'd0, 16'h000A, 16'h0014);
    send(1'b0, 4'd1, 16'h0032, 16'h0008);
    req0_valid = 1'b1; req0_op = 4'd2; req0_a = 16'hF0F0; req0_b = 16'h0FF0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_ready", {31'b0, s_r0}, 32'd0);
      chk("stall_hold_data", {15'b0, resp_valid, resp_data}, {15'b0, 1'b1, 16'h001E});
    end
    resp_ready = 1'b1;
    send(1'b0, 4'd2, 16'hF0F0, 16'h0FF0);
    drain();

    // Reset with both stages full; the stale zero-result must never surface
    resp_ready = 1'b0;
    send(1'b0, 4'd1, 16'h0005, 16'h0005);
    send(1'b1, 4'd0, 16'h0001, 16'h0002);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    m_flag = 3'b000;
    chk("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("midrst_flag", {29'b0, flag}, 32'd0);
    chk("midrst_cnt", {gnt_cnt0, gnt_cnt1}, 32'd0);
    resp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("midrst_no_stale", {31'b0, resp_valid}, 32'd0);
    end

    // Both requesters valid every cycle
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 16'h0001; req0_b = 16'h0002;
    req1_valid = 1'b1; req1_op = 4'd2; req1_a = 16'h0003; req1_b = 16'h0004;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("both_acc", {31'b0, acc}, 32'd1);
`ifdef ALU_SCHED_PRIO_EN
      chk("gnt_seq", {31'b0, acc_id}, 32'd0);
`else
      chk("gnt_seq", {31'b0, acc_id}, k % 2);
`endif
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
`ifdef ALU_SCHED_PRIO_EN
    chk("gnt_cnt0", {16'b0, gnt_cnt0}, 32'd4);
    chk("gnt_cnt1", {16'b0, gnt_cnt1}, 32'd0);
`else
    chk("gnt_cnt0", {16'b0, gnt_cnt0}, 32'd2);
    chk("gnt_cnt1", {16'b0, gnt_cnt1}, 32'd2);
`endif
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
